fb_pixel_writer: RTL and testbench

//  Write-side address generator for the 320x240 frame buffer BRAM; scan-out reads from the other port.

---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_pixel_writer_if.sv | 36 +++
 rtl/fb_row_base_calc.sv | 48 ++++
 rtl/fb_pixel_writer.sv | 104 ++++++++++
 tb/tb_fb_pixel_writer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer constants and writer state encoding.
//   H_RES/V_RES/FB_DEPTH describe the 320x240 buffer geometry; PIX_W is the RGB444 pixel width;
//   ADDR_W is the BRAM address width. The scan-out address generator uses the same constants.
package fb_pkg;

    localparam int H_RES    = 320;
    localparam int V_RES    = 240;
    localparam int FB_DEPTH = H_RES * V_RES;
    localparam int PIX_W    = 12;
    localparam int ADDR_W   = 17;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        CLEAR
    } state_t;

endpackage

// File: rtl/fb_pixel_writer_if.sv
// fb_pixel_writer_if: pixel-stream input, clear command and BRAM write port of the frame-buffer writer.
//   in_valid/in_ready/in_data/in_sof/base_row : raster pixel stream with frame-start marker and scroll row
//   clear_req/clear_color                     : one-cycle full-buffer fill request and its fill value
//   wr_en/wr_addr/wr_data                     : registered BRAM write port
//   busy/frame_done/sof_err                   : status (active, last write of frame/clear, early SOF)
//   master drives the stream and command, slave is the writer.
interface fb_pixel_writer_if #(
    parameter int PIX_W  = fb_pkg::PIX_W,
    parameter int ADDR_W = fb_pkg::ADDR_W
);

    logic              in_valid;
    logic              in_ready;
    logic [PIX_W-1:0]  in_data;
    logic              in_sof;
    logic [7:0]        base_row;
    logic              clear_req;
    logic [PIX_W-1:0]  clear_color;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              busy;
    logic              frame_done;
    logic              sof_err;

    modport master (
        output in_valid, in_data, in_sof, base_row, clear_req, clear_color,
        input  in_ready, wr_en, wr_addr, wr_data, busy, frame_done, sof_err
    );

    modport slave (
        input  in_valid, in_data, in_sof, base_row, clear_req, clear_color,
        output in_ready, wr_en, wr_addr, wr_data, busy, frame_done, sof_err
    );

endinterface

// File: rtl/fb_row_base_calc.sv
// fb_row_base_calc: logical row counter and physical row base address accumulator.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart at logical row 0 with base seed_row*H_RES (takes effect in this cycle)
//   step       : advance one line; base += H_RES, wrapping to 0 at H_RES*V_RES
//   seed_row   : physical row for logical row 0 (0 for a clear)
//   row        : current logical row (already reflects load)
//   row_base   : current physical row base address (already reflects load)
module fb_row_base_calc #(
    parameter int H_RES  = fb_pkg::H_RES,
    parameter int V_RES  = fb_pkg::V_RES,
    parameter int ADDR_W = fb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [7:0]        seed_row,
    output logic [7:0]        row,
    output logic [ADDR_W-1:0] row_base
);

    localparam int FB_DEPTH = H_RES * V_RES;

    logic [7:0]        row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   base_inc;

    // The only multiply happens once per frame on the seed; per-line updates are adds.
    assign row      = load ? 8'd0 : row_q;
    assign row_base = load ? ADDR_W'(int'(seed_row) * H_RES) : base_q;

    always_comb begin
        base_inc = {1'b0, row_base} + (ADDR_W+1)'(H_RES);
        row_d    = step ? row + 8'd1 : row;
        base_d   = step ? ((base_inc >= (ADDR_W+1)'(FB_DEPTH)) ? '0 : base_inc[ADDR_W-1:0]) : row_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            base_q <= '0;
        end else begin
            row_q  <= row_d;
            base_q <= base_d;
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: converts a raster pixel stream (or a fill command) into frame-buffer BRAM writes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fb_pixel_writer_if slave (stream in, clear command, BRAM write port, status)
//   Logical row y lands at physical row (y + base_row) mod V_RES so writes follow the scrolled scan-out.
module fb_pixel_writer #(
    parameter int H_RES  = fb_pkg::H_RES,
    parameter int V_RES  = fb_pkg::V_RES,
    parameter int PIX_W  = fb_pkg::PIX_W,
    parameter int ADDR_W = fb_pkg::ADDR_W
) (
    input logic              clk,
    input logic              rst_n,
    fb_pixel_writer_if.slave bus
);

    import fb_pkg::*;

    state_t            state_q, state_d;
    logic [8:0]        col_q, col_d, cur_col;
    logic [PIX_W-1:0]  color_q, color_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              sof_err_q, sof_err_d;
    logic              in_ready, acc, clear_go, load, wr, last_col, step, last;
    logic [7:0]        seed_row, row;
    logic [ADDR_W-1:0] row_base;

    // A clear request in IDLE wins over any stream beat presented in the same cycle.
    assign in_ready = (state_q == STREAM) | ((state_q == IDLE) & ~bus.clear_req);
    assign acc      = bus.in_valid & in_ready;
    assign clear_go = (state_q == IDLE) & bus.clear_req;
    assign load     = clear_go | (acc & bus.in_sof);
    assign seed_row = clear_go ? 8'd0 : bus.base_row;
    assign cur_col  = load ? 9'd0 : col_q;

    fb_row_base_calc #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_row_base (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .seed_row (seed_row),
        .row      (row),
        .row_base (row_base)
    );

    always_comb begin
        // Non-SOF beats accepted in IDLE are discarded; CLEAR writes one word every cycle.
        wr           = (acc & (bus.in_sof | (state_q == STREAM))) | (state_q == CLEAR);
        last_col     = cur_col == 9'(H_RES - 1);
        step         = wr & last_col;
        last         = step & (row == 8'(V_RES - 1));
        col_d        = wr ? (last_col ? 9'd0 : cur_col + 9'd1) : cur_col;
        color_d      = clear_go ? bus.clear_color : color_q;
        wr_en_d      = wr;
        wr_addr_d    = wr ? row_base + ADDR_W'(cur_col) : wr_addr_q;
        wr_data_d    = wr ? ((state_q == CLEAR) ? color_q : bus.in_data) : wr_data_q;
        frame_done_d = last;
        sof_err_d    = acc & bus.in_sof & (state_q == STREAM);
        state_d      = state_q;
        if (clear_go)
            state_d = CLEAR;
        else if (acc & bus.in_sof)
            state_d = STREAM;
        if (last)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            color_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            color_q      <= color_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = state_q != IDLE;
    assign bus.frame_done = frame_done_q;
    assign bus.sof_err    = sof_err_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: directed scenarios for fb_pixel_writer on a reduced 16x12 frame.
module tb_fb_pixel_writer;

    localparam int H = 16;
    localparam int V = 12;
    localparam int N = H * V;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_pixel_writer_if bus ();

    fb_pixel_writer #(
        .H_RES (H),
        .V_RES (V)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int wq[$];
    int dq[$];
    int cq[$];
    int fdq[$];
    int sofq[$];
    int lat_bad = 0;
    int cyc = 0;
    logic prev_wr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log plus an independent latency model: a write is due one cycle after an accepted
    // SOF beat, an accepted beat while busy (stream), or a busy cycle with in_ready low (clear).
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wr <= 1'b0;
        end else begin
            if (bus.wr_en !== prev_wr) lat_bad <= lat_bad + 1;
            if (bus.wr_en === 1'b1) begin
                wq.push_back(int'(bus.wr_addr));
                dq.push_back(int'(bus.wr_data));
                cq.push_back(cyc);
            end
            if (bus.frame_done === 1'b1) fdq.push_back(bus.wr_en ? wq.size() - 1 : -1);
            if (bus.sof_err === 1'b1) sofq.push_back(bus.wr_en ? wq.size() - 1 : -1);
            prev_wr <= (bus.in_valid & bus.in_ready & (bus.in_sof | bus.busy)) | (bus.busy & ~bus.in_ready);
        end
    end

    function automatic int exp_addr(int base, int i);
        return (((i / H) + base) % V) * H + (i % H);
    endfunction

    function automatic logic [11:0] pix(int base, int i);
        return 12'(base * 256 + i);
    endfunction

    task automatic clr_log();
        wq.delete();
        dq.delete();
        cq.delete();
        fdq.delete();
        sofq.delete();
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sof, input logic [11:0] d, input int gap);
        int n;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = d;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    // base_row is scrambled after the SOF beat so only the latched value may be used.
    task automatic send_frame(input int base, input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            if (i == 0) bus.base_row = 8'(base);
            send(i == 0, pix(base, i), maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
            if (i == 0) bus.base_row = 8'(V - 1 - base);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_sof = 0; bus.in_data = 0; bus.base_row = 0;
        bus.clear_req = 0; bus.clear_color = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b want=0", bus.wr_en); end
        checks++; if (bus.wr_addr !== 17'd0) begin errors++; $display("FAIL reset_wr_addr got=%0d want=0", bus.wr_addr); end
        checks++; if (bus.wr_data !== 12'd0) begin errors++; $display("FAIL reset_wr_data got=%h want=000", bus.wr_data); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if ({bus.frame_done, bus.sof_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b want=00", {bus.frame_done, bus.sof_err}); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();
    endtask

    task automatic test_stream_base0();
        int l0, bad;
        clr_log();
        l0 = lat_bad;
        bus.base_row = 8'd0;
        send(1'b1, pix(0, 0), 0);
        checks++; if ({bus.wr_en, bus.busy} !== 2'b11 || bus.wr_addr !== 17'd0) begin
            errors++; $display("FAIL first_write wr_en=%b busy=%b addr=%0d want 1 1 0", bus.wr_en, bus.busy, bus.wr_addr); end
        for (int i = 1; i < N; i++) send(1'b0, pix(0, i), 0);
        settle();
        checks++; if (wq.size() != N) begin errors++; $display("FAIL b0_count got=%0d want=%0d", wq.size(), N); end
        bad = -1;
        foreach (wq[k]) if (bad < 0 && (wq[k] != k || dq[k] != int'(pix(0, k)))) bad = k;
        checks++; if (bad >= 0) begin errors++; $display("FAIL b0_seq idx=%0d addr=%0d data=%0h want addr=%0d data=%0h", bad, wq[bad], dq[bad], bad, pix(0, bad)); end
        checks++; if (fdq.size() != 1 || fdq[0] != N - 1) begin errors++; $display("FAIL b0_frame_done pulses=%0d idx=%0d want 1 at %0d", fdq.size(), fdq.size() ? fdq[0] : -2, N - 1); end
        checks++; if (lat_bad - l0 != 0 || sofq.size() != 0) begin errors++; $display("FAIL b0_latency viol=%0d sof_err=%0d want 0 0", lat_bad - l0, sofq.size()); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b0_idle busy=%b want=0", bus.busy); end
    endtask

    task automatic test_scroll();
        int bad;
        clr_log();
        send_frame(V - 1, N, 0);
        settle();
        checks++; if (wq.size() != N) begin errors++; $display("FAIL scroll_count got=%0d want=%0d", wq.size(), N); end
        checks++; if (wq.size() > H && (wq[0] != (V - 1) * H || wq[H] != 0 || wq[N - 1] != (V - 1) * H - 1)) begin
            errors++; $display("FAIL scroll_corners got=%0d,%0d,%0d want=%0d,0,%0d", wq[0], wq[H], wq[N - 1], (V - 1) * H, (V - 1) * H - 1); end
        bad = -1;
        foreach (wq[k]) if (bad < 0 && (wq[k] != exp_addr(V - 1, k) || dq[k] != int'(pix(V - 1, k)))) bad = k;
        checks++; if (bad >= 0) begin errors++; $display("FAIL scroll_seq idx=%0d addr=%0d want=%0d", bad, wq[bad], exp_addr(V - 1, bad)); end
        checks++; if (fdq.size() != 1 || fdq[0] != N - 1) begin errors++; $display("FAIL scroll_frame_done pulses=%0d want 1 at %0d", fdq.size(), N - 1); end
    endtask

    task automatic test_idle_discard_gaps();
        int l0, bad, dup;
        int seen[N];
        clr_log();
        l0 = lat_bad;
        for (int i = 0; i < 5; i++) send(1'b0, 12'(100 + i), i % 3);
        settle();
        checks++; if (wq.size() != 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_discard writes=%0d busy=%b want 0 0", wq.size(), bus.busy); end
        send_frame(3, N, 3);
        settle();
        checks++; if (wq.size() != N) begin errors++; $display("FAIL gaps_count got=%0d want=%0d", wq.size(), N); end
        for (int a = 0; a < N; a++) seen[a] = 0;
        dup = 0;
        foreach (wq[k]) if (wq[k] >= 0 && wq[k] < N) seen[wq[k]]++;
        for (int a = 0; a < N; a++) if (seen[a] != 1) dup++;
        checks++; if (dup != 0) begin errors++; $display("FAIL gaps_coverage bad_addrs=%0d want=0", dup); end
        bad = -1;
        foreach (wq[k]) if (bad < 0 && wq[k] != exp_addr(3, k)) bad = k;
        checks++; if (bad >= 0) begin errors++; $display("FAIL gaps_seq idx=%0d addr=%0d want=%0d", bad, wq[bad], exp_addr(3, bad)); end
        checks++; if (lat_bad - l0 != 0) begin errors++; $display("FAIL gaps_latency viol=%0d want=0", lat_bad - l0); end
    endtask

    task automatic test_sof_restart();
        localparam int K = 3 * H + 10;
        int bad, e;
        clr_log();
        send_frame(2, K, 0);
        send_frame(5, N, 0);
        settle();
        checks++; if (wq.size() != K + N) begin errors++; $display("FAIL restart_count got=%0d want=%0d", wq.size(), K + N); end
        checks++; if (sofq.size() != 1 || sofq[0] != K) begin errors++; $display("FAIL restart_sof_err pulses=%0d idx=%0d want 1 at %0d", sofq.size(), sofq.size() ? sofq[0] : -2, K); end
        checks++; if (wq.size() > K && wq[K] != 5 * H) begin errors++; $display("FAIL restart_addr got=%0d want=%0d", wq[K], 5 * H); end
        bad = -1;
        foreach (wq[k]) begin
            e = (k < K) ? exp_addr(2, k) : exp_addr(5, k - K);
            if (bad < 0 && wq[k] != e) bad = k;
        end
        checks++; if (bad >= 0) begin errors++; $display("FAIL restart_seq idx=%0d addr=%0d", bad, wq[bad]); end
        checks++; if (fdq.size() != 1 || fdq[0] != K + N - 1) begin errors++; $display("FAIL restart_frame_done pulses=%0d want 1 at %0d", fdq.size(), K + N - 1); end
    endtask

    task automatic test_clear();
        int l0, n, bad;
        clr_log();
        l0 = lat_bad;
        bus.clear_color = 12'hF00;
        bus.clear_req = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sof = 1'b1;
        bus.base_row = 8'd4;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clear_wins_ready got=%b want=0", bus.in_ready); end
        @(posedge clk);
        #1;
        bus.clear_req = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        @(negedge clk);
        checks++; if ({bus.busy, bus.in_ready} !== 2'b10) begin errors++; $display("FAIL clear_busy busy=%b ready=%b want 1 0", bus.busy, bus.in_ready); end
        repeat (20) @(posedge clk);
        #1;
        bus.clear_color = 12'h0F0;
        bus.clear_req = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_req = 1'b0;
        n = 0;
        while (bus.busy && n < 2 * N) begin
            @(negedge clk);
            n++;
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clear_timeout busy=%b want=0", bus.busy); end
        settle();
        checks++; if (wq.size() != N) begin errors++; $display("FAIL clear_count got=%0d want=%0d", wq.size(), N); end
        bad = -1;
        foreach (wq[k]) if (bad < 0 && (wq[k] != k || dq[k] != 'hF00)) bad = k;
        checks++; if (bad >= 0) begin errors++; $display("FAIL clear_seq idx=%0d addr=%0d data=%0h want addr=%0d data=f00", bad, wq[bad], dq[bad], bad); end
        checks++; if (cq.size() == N && cq[N - 1] - cq[0] != N - 1) begin errors++; $display("FAIL clear_contiguous span=%0d want=%0d", cq[N - 1] - cq[0], N - 1); end
        checks++; if (fdq.size() != 1 || fdq[0] != N - 1) begin errors++; $display("FAIL clear_frame_done pulses=%0d want 1 at %0d", fdq.size(), N - 1); end
        checks++; if (lat_bad - l0 != 0) begin errors++; $display("FAIL clear_latency viol=%0d want=0", lat_bad - l0); end
    endtask

    task automatic test_reset_mid();
        int n0, bad;
        clr_log();
        send_frame(4, 7 * H + 3, 0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({bus.wr_en, bus.busy, bus.frame_done, bus.sof_err} !== 4'b0000 || bus.wr_addr !== 17'd0 || bus.wr_data !== 12'd0) begin
            errors++; $display("FAIL midreset_outputs en=%b busy=%b fd=%b se=%b addr=%0d data=%h want all 0", bus.wr_en, bus.busy, bus.frame_done, bus.sof_err, bus.wr_addr, bus.wr_data); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();
        n0 = wq.size();
        send_frame(4, N, 0);
        settle();
        checks++; if (wq.size() - n0 != N) begin errors++; $display("FAIL midreset_count got=%0d want=%0d", wq.size() - n0, N); end
        bad = -1;
        for (int k = 0; k < wq.size() - n0; k++) if (bad < 0 && wq[n0 + k] != exp_addr(4, k)) bad = k;
        checks++; if (bad >= 0) begin errors++; $display("FAIL midreset_seq idx=%0d addr=%0d want=%0d", bad, wq[n0 + bad], exp_addr(4, bad)); end
        checks++; if (fdq.size() != 1 || fdq[0] != n0 + N - 1) begin errors++; $display("FAIL midreset_frame_done pulses=%0d want 1 at %0d", fdq.size(), n0 + N - 1); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream_base0();
        test_scroll();
        test_idle_discard_gaps();
        test_sof_restart();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
